// File: rtl/uart_cmd_host.sv
// uart_cmd_host
// -------------
// Serial command initiator for a byte-level UART command target (for example
// an SDRAM controller's i_rx/o_tx pins). A parallel request is turned into
// a UART byte sequence:
//   write: 'w' (0x77), address, data      -> completes with no reply expected
//   read : 'r' (0x72), address            -> waits for one reply byte
// Frames are 8N1, LSB first, B = ClockFreq/BaudRate cycles per bit. The
// bytes of one command are sent back to back with no idle gap.
//
// Ports
//   i_sys_clk    system clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_req_valid  request present
//   o_req_ready  request can be taken (idle, and not in the response cycle)
//   i_req_write  1 = write, 0 = read
//   i_req_addr   command address byte
//   i_req_wdata  write data byte (unused for reads)
//   o_rsp_valid  one-cycle completion pulse
//   o_rsp_rdata  read data (0 for writes and timeouts)
//   o_rsp_error  timeout or bad stop bit, qualified by o_rsp_valid
//   o_busy       high from acceptance through the o_rsp_valid cycle
//   o_tx         UART serial out, idles high
//   i_rx         UART serial in, asynchronous to i_sys_clk
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both high. The request fields are captured on that edge;
// later changes on the request inputs are ignored until the next transfer.
// There is no back-pressure on the response side: o_rsp_valid is a single
// cycle pulse that the requester must take when it appears.

module uart_cmd_host #(
    parameter int ClockFreq  = 133_000_000,
    parameter int BaudRate   = 115200,
    parameter int RspTimeout = 2_000_000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_write,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_error,
    output logic       o_busy,
    output logic       o_tx,
    input  logic       i_rx
);

    localparam int BitCycles = ClockFreq / BaudRate;
    localparam int HalfBit   = BitCycles / 2;
    localparam int CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
    localparam int TmoW      = $clog2(RspTimeout + 1);

    localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(RspTimeout - 1);
    localparam logic [3:0]      IdxLast  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RSP,
        RECV,
        DONE
    } state_t;

    // state is kept as a named enum register so checkers can bind to it
    state_t state;
    state_t state_nxt;

    logic            req_write_r;
    logic [7:0]      req_addr_r;
    logic [7:0]      req_wdata_r;
    logic [9:0]      tx_shift;     // {stop, data[7:0], start}, shifted out LSB first
    logic [CntW-1:0] cnt;          // cycles within the current bit (tx and rx share it)
    logic [3:0]      idx;          // bit position within the current frame
    logic [TmoW-1:0] tmo;
    logic            start_pend;   // falling edge seen, waiting for mid-start check
    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    logic [7:0]      rx_shift;
    logic [7:0]      res_data;
    logic            res_err;

    logic accept;
    logic bit_end;
    logic rx_fall;
    logic start_ok;
    logic tmo_hit;

    // Ready is withheld during the response cycle so a new request never
    // overlaps the completion pulse of the previous one.
    assign o_req_ready = (state == IDLE) && !o_rsp_valid;
    assign o_busy      = !o_req_ready;
    assign accept      = i_req_valid && o_req_ready;

    assign bit_end  = (cnt == BitLast) && (idx == IdxLast);
    assign rx_fall  = rx_prev && !rx_s2;
    assign start_ok = start_pend && (cnt == HalfLast) && !rx_s2;
    assign tmo_hit  = (tmo == TmoLast);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept)  state_nxt = SEND_CMD;
            SEND_CMD:  if (bit_end) state_nxt = SEND_ADDR;
            SEND_ADDR: if (bit_end) state_nxt = req_write_r ? SEND_DATA : WAIT_RSP;
            SEND_DATA: if (bit_end) state_nxt = DONE;
            WAIT_RSP: begin
                if (tmo_hit) begin
                    state_nxt = DONE;
                end else if (start_ok) begin
                    state_nxt = RECV;
                end
            end
            RECV:      if (bit_end) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            o_tx        <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 8'h00;
            o_rsp_error <= 1'b0;
            req_write_r <= 1'b0;
            req_addr_r  <= 8'h00;
            req_wdata_r <= 8'h00;
            tx_shift    <= 10'h3ff;
            cnt         <= '0;
            idx         <= 4'd0;
            tmo         <= '0;
            start_pend  <= 1'b0;
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_shift    <= 8'h00;
            res_data    <= 8'h00;
            res_err     <= 1'b0;
        end else begin
            rx_s1       <= i_rx;
            rx_s2       <= rx_s1;
            rx_prev     <= rx_s2;
            o_rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (accept) begin
                        req_write_r <= i_req_write;
                        req_addr_r  <= i_req_addr;
                        req_wdata_r <= i_req_wdata;
                        tx_shift    <= {1'b1, (i_req_write ? 8'h77 : 8'h72), 1'b0};
                        cnt         <= '0;
                        idx         <= 4'd0;
                    end
                end

                SEND_CMD, SEND_ADDR, SEND_DATA: begin
                    o_tx <= tx_shift[0];
                    if (cnt == BitLast) begin
                        cnt <= '0;
                        if (idx == IdxLast) begin
                            // Stop bit is on the line now; preload the next
                            // frame so its start bit follows with no gap.
                            idx <= 4'd0;
                            if (state == SEND_CMD) begin
                                tx_shift <= {1'b1, req_addr_r, 1'b0};
                            end else if (state == SEND_ADDR && req_write_r) begin
                                tx_shift <= {1'b1, req_wdata_r, 1'b0};
                            end else if (state == SEND_ADDR) begin
                                tmo        <= '0;
                                start_pend <= 1'b0;
                            end else begin
                                res_data <= 8'h00;
                                res_err  <= 1'b0;
                            end
                        end else begin
                            idx      <= idx + 4'd1;
                            tx_shift <= {1'b1, tx_shift[9:1]};
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                WAIT_RSP: begin
                    // The mid-start check lives here, not in RECV, so a
                    // glitch costs no time against the reply timeout.
                    o_tx <= 1'b1;
                    tmo  <= tmo + TmoW'(1);
                    if (tmo_hit) begin
                        res_data <= 8'h00;
                        res_err  <= 1'b1;
                    end else if (start_pend) begin
                        if (cnt == HalfLast) begin
                            cnt        <= '0;
                            start_pend <= 1'b0;
                            idx        <= 4'd1;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end else if (rx_fall) begin
                        start_pend <= 1'b1;
                        cnt        <= '0;
                    end
                end

                RECV: begin
                    o_tx <= 1'b1;
                    if (cnt == BitLast) begin
                        cnt <= '0;
                        if (idx == IdxLast) begin
                            res_data <= rx_shift;
                            res_err  <= !rx_s2;
                        end else begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            idx      <= idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                DONE: begin
                    o_tx        <= 1'b1;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= res_data;
                    o_rsp_error <= res_err;
                end

                default: begin
                    o_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host with B = 10 cycles per bit and a 1000-cycle reply
// timeout. A UART monitor decodes o_tx against an expected byte queue, a
// responder task drives i_rx, and a compare process checks busy/ready and
// every response pulse against an expected response queue.

module tb_uart_cmd_host;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int TMO    = 1000;
  localparam int B      = CLK_HZ / BAUD;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lo;
    int         hi;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       busy;
  logic       tx;
  logic       rx = 1'b1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rsp_seen = 0;
  logic exp_busy = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_start_q[$];
  rsp_t       rsp_q[$];

  uart_cmd_host #(
    .ClockFreq (CLK_HZ),
    .BaudRate  (BAUD),
    .RspTimeout(TMO)
  ) dut (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_addr (req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error),
    .o_busy     (busy),
    .o_tx       (tx),
    .i_rx       (rx)
  );

  // clock / cycle count: cyc equals the number of rising edges so far
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: actual=%0d required=[%0d..%0d]", nm, act, lo, hi);
    end
  endtask

  // driver tasks (entered and left just after a rising edge)
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d, output int t);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) $display("FAIL req_accept_timeout: ready never rose, cycle %0d", cyc);
    @(posedge clk);
    #1;
    t = cyc;
    exp_busy  = 1'b1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~d;
    req_write = ~wr;
  endtask

  task automatic push_tx(input int t, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n);
    exp_q.push_back(b0); exp_start_q.push_back(t + 1);
    exp_q.push_back(b1); exp_start_q.push_back(t + 1 + 10 * B);
    if (n > 2) begin
      exp_q.push_back(b2); exp_start_q.push_back(t + 1 + 20 * B);
    end
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic e, input int lo, input int hi);
    rsp_t r;
    r.rdata = d;
    r.err   = e;
    r.lo    = lo;
    r.hi    = hi;
    rsp_q.push_back(r);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      repeat (B) begin
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
  endtask

  // UART monitor on o_tx: samples each bit in its middle
  initial begin : tx_mon
    int         s;
    logic [9:0] fr;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        s  = cyc;
        ab = 1'b0;
        fr = '1;
        for (int k = 0; k < 10; k++) begin
          while (cyc < s + B / 2 + B * k && !ab) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
          end
          if (ab) break;
          fr[k] = tx;
        end
        if (!ab) begin
          chk("tx_start_bit", {31'd0, fr[0]}, 32'd0);
          chk("tx_stop_bit", {31'd0, fr[9]}, 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected_byte: actual=%0h required=none at cycle %0d", fr[8:1], s);
          end else begin
            chk("tx_byte", {24'd0, fr[8:1]}, {24'd0, exp_q.pop_front()});
            chk("tx_frame_start", s, exp_start_q.pop_front());
          end
        end
      end
    end
  end

  // scoreboard compare process: every cycle out of reset
  rsp_t cur;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("ready", {31'd0, req_ready}, {31'd0, !exp_busy});
      if (rsp_valid) begin
        rsp_seen++;
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: actual=valid required=none at cycle %0d", cyc);
        end else begin
          cur = rsp_q.pop_front();
          chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, cur.rdata});
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, cur.err});
          chk_range("rsp_cycle", cyc, cur.lo, cur.hi);
        end
        exp_busy = 1'b0;
      end
    end
  end

  // main sequence
  initial begin
    int t;
    int s;
    int e;
    int base;

    // 1: reset for two cycles, then quiet
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    base = rsp_seen;
    wait_cyc(cyc + 100);
    chk("idle_no_rsp", rsp_seen - base, 0);

    // 2: write 0x05 <- 0x17
    do_req(1'b1, 8'h05, 8'h17, t);
    push_tx(t, 8'h77, 8'h05, 8'h17, 3);
    push_rsp(8'h00, 1'b0, t + 301, t + 301);
    wait_cyc(t + 1);
    chk("wr_tx_low_t1", {31'd0, tx}, 32'd0);
    wait_cyc(t + 300);
    chk("wr_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    wait_cyc(t + 301);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    chk("wr_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("wr_ready_low_in_rsp", {31'd0, req_ready}, 32'd0);
    wait_cyc(t + 302);
    chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
    chk("wr_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

    // 3: read 0x05, reply 0x9A 50 cycles after the address stop bit
    base = rsp_seen;
    do_req(1'b0, 8'h05, 8'h00, t);
    push_tx(t, 8'h72, 8'h05, 8'h00, 2);
    wait_cyc(t + 201 + 50 - 1);
    s = cyc;
    push_rsp(8'h9A, 1'b0, s + 95, s + 105);
    send_rx(8'h9A, 1'b1);
    wait_cyc(s + 120);
    chk("rd_one_rsp", rsp_seen - base, 1);

    // 4: read 0x0F, no reply, short glitch at WAIT_RSP entry + 200
    base = rsp_seen;
    do_req(1'b0, 8'h0F, 8'h00, t);
    push_tx(t, 8'h72, 8'h0F, 8'h00, 2);
    e = t + 1 + 20 * B;
    push_rsp(8'h00, 1'b1, e + TMO - 1, e + TMO + 1);
    wait_cyc(e + 200);
    rx = 1'b0;
    wait_cyc(e + 203);
    rx = 1'b1;
    wait_cyc(e + 990);
    chk("to_glitch_no_rsp", rsp_seen - base, 0);
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    wait_cyc(e + TMO + 10);
    chk("to_one_rsp", rsp_seen - base, 1);

    // 5: read 0x33, reply 0x23 with a bad stop bit
    base = rsp_seen;
    do_req(1'b0, 8'h33, 8'h00, t);
    push_tx(t, 8'h72, 8'h33, 8'h00, 2);
    wait_cyc(t + 250);
    s = cyc;
    push_rsp(8'h23, 1'b1, s + 95, s + 105);
    send_rx(8'h23, 1'b0);
    wait_cyc(s + 120);
    chk("bad_stop_one_rsp", rsp_seen - base, 1);

    // 6a: write aborted by reset at T+150 (address bit 3 = 0 is on the line)
    do_req(1'b1, 8'h30, 8'h99, t);
    push_tx(t, 8'h77, 8'h30, 8'h99, 3);
    push_rsp(8'h00, 1'b0, t + 301, t + 301);
    wait_cyc(t + 150);
    chk("abort_tx_before_rst", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_start_q.delete();
    rsp_q.delete();
    base = rsp_seen;
    @(posedge clk);
    #1;
    exp_busy = 1'b0;
    chk("abort_tx_high", {31'd0, tx}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    wait_cyc(cyc + 400);
    chk("abort_no_rsp", rsp_seen - base, 0);

    // 6b: request inputs toggled while busy must not be accepted
    base = rsp_seen;
    do_req(1'b1, 8'h44, 8'h55, t);
    push_tx(t, 8'h77, 8'h44, 8'h55, 3);
    push_rsp(8'h00, 1'b0, t + 301, t + 301);
    for (int i = 0; i < 40; i++) begin
      req_valid = ~req_valid;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 255));
      req_wdata = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_cyc(t + 320);
    chk("busy_toggle_one_rsp", rsp_seen - base, 1);

    // final report
    wait_cyc(cyc + 20);
    chk("tx_queue_drained", exp_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
